// File: rtl/nios_f_oci_pkg.sv
// Shared parameters and types for the Nios OCI data-compressed-trace path.
package nios_f_oci_pkg;

  localparam int unsigned ATOM_W = 2;
  localparam int unsigned SLOTS  = 15;
  localparam int unsigned BUF_W  = ATOM_W * SLOTS;
  localparam int unsigned CNT_W  = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } dct_state_e;

endpackage

// File: rtl/nios_f_oci_dct_hold.sv
// One-entry valid/ready hold register between the DCT packer and the trace-memory writer.
module nios_f_oci_dct_hold
  import nios_f_oci_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BUF_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             hold_free
);

  logic             valid_q, valid_d;
  logic [BUF_W-1:0] data_q;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    hold_free = !valid_q || out_ready;
    // A reload in the same cycle as a consume keeps the register occupied.
    valid_d   = load || (valid_q && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        data_q  <= load_data;
        count_q <= load_count;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_count = count_q;

endmodule

// File: rtl/nios_f_oci_dct_ctrl.sv
// DCT sequencing controller: packs trace atoms LSB-first into the working buffer,
// hands full or flushed buffers to the hold register and drives end-of-trace flags.
module nios_f_oci_dct_ctrl
  import nios_f_oci_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              flush_req,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  output logic              atom_ready,
  output logic              out_valid,
  output logic [BUF_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_ending,
  output logic              test_has_ended
);

  localparam logic [CNT_W-1:0] FullCount = CNT_W'(SLOTS);

  dct_state_e       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] base_cnt;
  logic             hold_free;
  logic             accept;
  logic             transfer;

  nios_f_oci_dct_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (transfer),
    .load_data  (buf_q),
    .load_count (cnt_q),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .hold_free  (hold_free)
  );

  always_comb begin
    atom_ready = (state_q == StRun) && ((cnt_q < FullCount) || hold_free);
    accept     = atom_valid && atom_ready;
    transfer   = hold_free &&
                 ((cnt_q == FullCount) || ((state_q == StFlush) && (cnt_q != '0)));
  end

  // A transfer empties the buffer first so a same-cycle atom lands in slot 0.
  always_comb begin
    buf_d    = transfer ? '0 : buf_q;
    base_cnt = transfer ? '0 : cnt_q;
    cnt_d    = base_cnt;
    if (accept) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (base_cnt == CNT_W'(i)) begin
          buf_d[i*ATOM_W +: ATOM_W] = atom;
        end
      end
      cnt_d = base_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    test_has_ended = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trace_en) state_d = StRun;
      end
      StRun: begin
        if (flush_req || !trace_en) state_d = StFlush;
      end
      StFlush: begin
        if ((cnt_q == '0) && !out_valid) begin
          state_d        = StIdle;
          test_has_ended = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dct_buffer  = buf_q;
  assign dct_count   = cnt_q;
  assign test_ending = (state_q == StFlush);

endmodule

// File: tb/tb_nios_f_oci_dct_ctrl.sv
// Scoreboard bench for nios_f_oci_dct_ctrl: stimulus queues expected words, a monitor checks them.
module tb_nios_f_oci_dct_ctrl;
  import nios_f_oci_pkg::*;

  logic              clk;
  logic              reset;
  logic              trace_en;
  logic              flush_req;
  logic              atom_valid;
  logic [ATOM_W-1:0] atom;
  logic              atom_ready;
  logic              out_valid;
  logic [BUF_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_ready;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_ending;
  logic              test_has_ended;

  typedef struct packed {
    logic [BUF_W-1:0] data;
    logic [CNT_W-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   cyc       = 0;
  int   acc_cyc   = -100;
  int   stalls    = 0;

  nios_f_oci_dct_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .trace_en       (trace_en),
    .flush_req      (flush_req),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .atom_ready     (atom_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_count      (out_count),
    .out_ready      (out_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [BUF_W-1:0] d, input logic [CNT_W-1:0] c);
    exp_t e;
    e.data  = d;
    e.count = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_word: got data 0x%0h count %0d, required no word",
                 out_data, out_count);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", 32'(out_data), 32'(mon_e.data));
        check("word_count", 32'(out_count), 32'(mon_e.count));
      end
      acc_cyc = cyc;
    end
  end

  task automatic offer(input logic [ATOM_W-1:0] a);
    int waited;
    waited     = 0;
    atom_valid = 1'b1;
    atom       = a;
    @(negedge clk);
    while (!atom_ready && waited < 300) begin
      waited++;
      stalls++;
      @(negedge clk);
    end
    if (!atom_ready) check("atom_accept_timeout", 32'(atom_ready), 32'd1);
    @(posedge clk);
    #1;
    atom_valid = 1'b0;
  endtask

  task automatic start_trace();
    trace_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic end_trace();
    int waited;
    waited   = 0;
    trace_en = 1'b0;
    @(negedge clk);
    while (!test_has_ended && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check("drain_done", 32'(test_has_ended), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int te_n, th_n, ov_n, waited, th_cyc;
    reset      = 1'b1;
    trace_en   = 1'b0;
    flush_req  = 1'b0;
    atom_valid = 1'b0;
    atom       = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dct_count", 32'(dct_count), 32'd0);
    check("rst_atom_ready", 32'(atom_ready), 32'd0);
    check("rst_test_ending", 32'(test_ending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 15 atoms of 01 -> one full word, one cycle after the 15th acceptance.
    push_exp(30'h15555555, 4'd15);
    start_trace();
    for (int i = 0; i < 15; i++) offer(2'b01);
    @(negedge clk);
    check("full_count_before_xfer", 32'(dct_count), 32'd15);
    check("no_valid_before_xfer", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("valid_after_xfer", 32'(out_valid), 32'd1);
    check("count_cleared", 32'(dct_count), 32'd0);
    end_trace();

    // 30 back-to-back atoms: no stall allowed.
    push_exp(30'h2AAAAAAA, 4'd15);
    push_exp(30'h3FFFFFFF, 4'd15);
    start_trace();
    stalls = 0;
    for (int i = 0; i < 15; i++) offer(2'b10);
    for (int i = 0; i < 15; i++) offer(2'b11);
    check("no_stall_b2b", 32'(stalls), 32'd0);
    end_trace();

    // Backpressure: 45 atoms with out_ready low until both buffers are full.
    push_exp(30'h15555555, 4'd15);
    push_exp(30'h2AAAAAAA, 4'd15);
    push_exp(30'h3FFFFFFF, 4'd15);
    out_ready = 1'b0;
    start_trace();
    fork
      begin
        for (int i = 0; i < 15; i++) offer(2'b01);
        for (int i = 0; i < 15; i++) offer(2'b10);
        for (int i = 0; i < 15; i++) offer(2'b11);
      end
      begin
        repeat (40) @(negedge clk);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", 32'(out_data), 32'h15555555);
        check("bp_dct_count", 32'(dct_count), 32'd15);
        check("bp_atom_ready", 32'(atom_ready), 32'd0);
        check("bp_dct_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    end_trace();

    // Partial buffer with flush_req coincident with the last atom.
    push_exp(30'h0000001B, 4'd3);
    start_trace();
    offer(2'b11);
    offer(2'b10);
    flush_req = 1'b1;
    offer(2'b01);
    flush_req = 1'b0;
    @(negedge clk);
    check("flush_test_ending", 32'(test_ending), 32'd1);
    waited = 0;
    while (!test_has_ended && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    th_cyc = cyc;
    check("flush_ended_pulse", 32'(test_has_ended), 32'd1);
    check("flush_ending_at_end", 32'(test_ending), 32'd1);
    check("ended_after_accept", 32'(th_cyc - acc_cyc), 32'd1);

    // trace_en still high: back to RUN, then drop it with an empty buffer.
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    trace_en = 1'b0;
    te_n = 0;
    th_n = 0;
    ov_n = 0;
    repeat (6) begin
      @(negedge clk);
      if (test_ending) te_n++;
      if (test_has_ended) th_n++;
      if (out_valid) ov_n++;
    end
    check("empty_flush_ending_cycles", 32'(te_n), 32'd1);
    check("empty_flush_ended_pulses", 32'(th_n), 32'd1);
    check("empty_flush_no_valid", 32'(ov_n), 32'd0);

    // Reset mid-operation with a held word and count 7: nothing emitted.
    out_ready = 1'b0;
    start_trace();
    for (int i = 0; i < 15; i++) offer(2'b10);
    for (int i = 0; i < 7; i++) offer(2'b01);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_count", 32'(dct_count), 32'd7);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    trace_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_count", 32'(out_count), 32'd0);
    check("mid_rst_dct_buffer", 32'(dct_buffer), 32'd0);
    check("mid_rst_dct_count", 32'(dct_count), 32'd0);
    check("mid_rst_flags", 32'({atom_ready, test_ending, test_has_ended}), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    ov_n = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) ov_n++;
    end
    check("post_rst_no_word", 32'(ov_n), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
